object_fetcher: RTL and testbench

//   Read-side master for object_buffer: on each frame start it rewinds the buffer,

---
 rtl/object_fetcher_pkg.sv | 10 +
 rtl/object_fetcher.sv | 127 ++++++++++++
 tb/tb_object_fetcher.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_fetcher_pkg.sv
// Shared payload types for the object buffer read path.
package object_fetcher_pkg;

  typedef struct packed {
    logic [23:0] color;
    logic [9:0]  x;
    logic [9:0]  y;
  } object_t;

endpackage

// File: rtl/object_fetcher.sv
// Read-side master for object_buffer: rewinds the buffer on frame start and streams
// every stored object downstream over a valid/ready handshake.
module object_fetcher
  import object_fetcher_pkg::*;
#(
  parameter  int unsigned MAX_OBJECTS = 50,
  localparam int unsigned IW          = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          frame_start,
  input  object_t       buf_data,
  input  logic          buf_read_end,
  output logic          buf_switch,
  output logic          buf_read,
  output object_t       obj_out,
  output logic          obj_valid,
  input  logic          obj_ready,
  output logic [IW-1:0] obj_index,
  output logic          obj_last,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REWIND  = 3'd1,
    SETTLE  = 3'd2,
    PRESENT = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_OBJECTS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  object_t       obj_out_q, obj_out_d;
  logic [IW-1:0] obj_index_q, obj_index_d;
  logic          obj_last_q, obj_last_d;
  logic          obj_valid_q, obj_valid_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          buf_switch_q, buf_switch_d;
  logic          buf_read_q, buf_read_d;

  // Next-state, payload capture and output decode (outputs decoded from next state
  // so every pin is a clean flop aligned with the state it belongs to).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    obj_out_d   = obj_out_q;
    obj_index_d = obj_index_q;
    obj_last_d  = obj_last_q;

    case (state_q)
      IDLE: begin
        if (frame_start) state_d = REWIND;
      end
      REWIND: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        obj_out_d   = buf_data;
        obj_last_d  = buf_read_end || (cnt_q == LAST_IDX);
        obj_index_d = cnt_q;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (obj_ready) begin
          if (obj_last_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + IW'(1);
            state_d = ADVANCE;
          end
        end
      end
      ADVANCE: state_d = SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    obj_valid_d  = (state_d == PRESENT);
    buf_switch_d = (state_d == REWIND);
    buf_read_d   = (state_d == ADVANCE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      obj_out_q    <= '0;
      obj_index_q  <= '0;
      obj_last_q   <= 1'b0;
      obj_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      buf_switch_q <= 1'b0;
      buf_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      obj_out_q    <= obj_out_d;
      obj_index_q  <= obj_index_d;
      obj_last_q   <= obj_last_d;
      obj_valid_q  <= obj_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      buf_switch_q <= buf_switch_d;
      buf_read_q   <= buf_read_d;
    end
  end

  assign obj_out    = obj_out_q;
  assign obj_index  = obj_index_q;
  assign obj_last   = obj_last_q;
  assign obj_valid  = obj_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign buf_switch = buf_switch_q;
  assign buf_read   = buf_read_q;

endmodule

// File: tb/tb_object_fetcher.sv
// Bench for object_fetcher: object_buffer model, frame-level reference of the expected
// object stream, and a per-cycle compare of handshake, payload and buffer pin rules.
module tb_object_fetcher;
  import object_fetcher_pkg::*;

  localparam int unsigned MAXO = 8;
  localparam int unsigned IW   = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          obj_ready = 1'b0;
  object_t       buf_data;
  logic          buf_read_end;
  logic          buf_switch, buf_read;
  object_t       obj_out;
  logic          obj_valid;
  logic [IW-1:0] obj_index;
  logic          obj_last, busy, frame_done;

  always #5 clock = ~clock;

  object_fetcher #(.MAX_OBJECTS(MAXO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .buf_data    (buf_data),
    .buf_read_end(buf_read_end),
    .buf_switch  (buf_switch),
    .buf_read    (buf_read),
    .obj_out     (obj_out),
    .obj_valid   (obj_valid),
    .obj_ready   (obj_ready),
    .obj_index   (obj_index),
    .obj_last    (obj_last),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // object_buffer read port: switch rewinds, rising edge of read advances
  object_t mem [16];
  int      n_written = 0;
  bit      tie_end0 = 1'b0;
  int      cursor;
  logic    read_prev;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor    <= 0;
      read_prev <= 1'b0;
    end else begin
      read_prev <= buf_read;
      if (buf_switch) cursor <= 0;
      else if (buf_read && !read_prev) cursor <= cursor + 1;
    end
  end

  assign buf_data     = mem[cursor[3:0]];
  assign buf_read_end = !tie_end0 && (n_written > 0) && (cursor == n_written - 1);

  // reference stream and bookkeeping
  object_t     exp_obj [MAXO];
  bit          exp_last [MAXO];
  int          exp_len = 0;
  int          ptr = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rd_total = 0;
  int          cyc_g = 0;
  int          ready_mode = 3;
  logic [23:0] acc_color [MAXO];
  bit          prev_valid, prev_acc, prev_last, prev_read, done_expect;
  object_t     prev_out;
  logic [IW-1:0] prev_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input int n, input bit tie0, input bit fixed);
    for (int i = 0; i < 16; i++)
      mem[i] = '{color: 24'($urandom), x: 10'($urandom), y: 10'($urandom)};
    if (fixed) begin
      mem[0].color = 24'h62B6B7;
      mem[6].color = 24'hFC8210;
    end
    n_written = n;
    tie_end0  = tie0;
  endtask

  // Frame stream: slots from 0 until the buffer's last slot or the object cap.
  task automatic build_expected();
    exp_len = 0;
    for (int i = 0; i < int'(MAXO); i++) begin
      exp_obj[i]  = mem[i];
      exp_last[i] = (!tie_end0 && i == n_written - 1) || (i == int'(MAXO) - 1);
      exp_len++;
      if (exp_last[i]) break;
    end
    ptr = 0;
    for (int i = 0; i < int'(MAXO); i++) acc_color[i] = '0;
  endtask

  task automatic sample();
    bit acc;
    if (!reset_n) begin
      check("rst_valid", 64'(obj_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(frame_done), 64'(0));
      check("rst_pins", 64'({buf_read, buf_switch}), 64'(0));
      check("rst_payload", 64'({obj_out, obj_index, obj_last}), 64'(0));
      prev_valid  = 1'b0;
      prev_acc    = 1'b0;
      prev_read   = 1'b0;
      done_expect = 1'b0;
      return;
    end
    check("read_switch_overlap", 64'(buf_read && buf_switch), 64'(0));
    check("read_back_to_back", 64'(buf_read && prev_read), 64'(0));
    if (buf_read && !prev_read) rd_total++;
    if (prev_valid && !prev_acc) begin
      check("stall_valid", 64'(obj_valid), 64'(1));
      check("stall_payload", 64'({obj_out, obj_index, obj_last}),
            64'({prev_out, prev_idx, prev_last}));
    end
    check("frame_done", 64'(frame_done), 64'(done_expect));
    done_expect = 1'b0;
    if (obj_valid) check("valid_busy", 64'(busy), 64'(1));
    acc = obj_valid && obj_ready;
    if (acc) begin
      check("accept_expected", 64'(ptr < exp_len), 64'(1));
      if (ptr < exp_len) begin
        check("obj_out", 64'(obj_out), 64'(exp_obj[ptr]));
        check("obj_index", 64'(obj_index), 64'(ptr));
        check("obj_last", 64'(obj_last), 64'(exp_last[ptr]));
        acc_color[ptr] = obj_out.color;
        done_expect    = exp_last[ptr];
        ptr++;
      end
    end
    prev_valid = obj_valid;
    prev_acc   = acc;
    prev_out   = obj_out;
    prev_idx   = obj_index;
    prev_last  = obj_last;
    prev_read  = buf_read;
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    cyc_g++;
    case (ready_mode)
      0:       obj_ready = 1'b1;
      1:       obj_ready = (cyc_g % 3 == 0);
      2:       obj_ready = 1'($urandom_range(0, 1));
      default: obj_ready = 1'b0;
    endcase
  endtask

  // One whole frame; exp_cycles>0 pins frame_start-sample-edge to frame_done.
  task automatic run_frame(input int exp_cycles, input bit poke);
    int cyc;
    bit done;
    int rd0;
    build_expected();
    rd0 = rd_total;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check("lat_busy", 64'(busy), 64'(1));
        check("lat_valid_early", 64'(obj_valid), 64'(0));
      end
      if (cyc == 2) check("lat_valid", 64'(obj_valid), 64'(1));
      if (poke && cyc == 4) frame_start = 1'b1;
      if (poke && cyc == 5) frame_start = 1'b0;
      if (frame_done) done = 1'b1;
    end
    frame_start = 1'b0;
    check("frame_done_seen", 64'(done), 64'(1));
    if (exp_cycles > 0) check("frame_cycles", 64'(cyc), 64'(exp_cycles));
    check("read_pulses", 64'(rd_total - rd0), 64'(exp_len - 1));
    check("objects_accepted", 64'(ptr), 64'(exp_len));
    tick();
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    reset_n = 1'b0;
    ready_mode = 3;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 7 objects, ready held high
    preload(7, 1'b0, 1'b1);
    ready_mode = 0;
    run_frame(21, 1'b0);
    check("lit_color0", 64'(acc_color[0]), 64'(24'h62B6B7));
    check("lit_color6", 64'(acc_color[6]), 64'(24'hFC8210));

    // same preload, ready 1-of-3
    ready_mode = 1;
    run_frame(0, 1'b0);
    check("stall_color6", 64'(acc_color[6]), 64'(24'hFC8210));

    // single-object frame
    preload(1, 1'b0, 1'b0);
    ready_mode = 0;
    run_frame(3, 1'b0);

    // unterminated buffer: cap ends the frame
    preload(16, 1'b1, 1'b0);
    run_frame(int'(MAXO) * 3, 1'b0);

    // reset while index 3 is presented
    preload(7, 1'b0, 1'b1);
    build_expected();
    ready_mode = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (obj_valid && obj_index == IW'(3)) found = 1'b1;
    end
    check("reach_idx3", 64'(found), 64'(1));
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(obj_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_payload", 64'({obj_out, obj_index, obj_last}), 64'(0));
    exp_len = 0;
    ptr = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    run_frame(21, 1'b0);
    check("post_rst_color0", 64'(acc_color[0]), 64'(24'h62B6B7));

    // frame_start while busy is ignored; next frame identical
    run_frame(21, 1'b1);
    run_frame(21, 1'b0);
    check("repeat_color6", 64'(acc_color[6]), 64'(24'hFC8210));

    // random frames with random back-pressure
    for (int f = 0; f < 8; f++) begin
      preload($urandom_range(1, MAXO + 2), ($urandom_range(0, 4) == 0), 1'b0);
      ready_mode = 2;
      run_frame(0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
